// File: rtl/apb_wait_slave_if.sv
// rtl/apb_wait_slave_if.sv - APB bus bundle between the master FSM and the wait-state completer
interface apb_wait_slave_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              PSEL;
  logic              PEN;
  logic              PWR;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDAT;
  logic              PRDY;
  logic [DATA_W-1:0] PRDAT;
  logic              PSLVERR;
  logic              PROTERR;

  modport master (
    output PSEL, PEN, PWR, PADDR, PWDAT,
    input  PRDY, PRDAT, PSLVERR, PROTERR
  );

  modport slave (
    input  PSEL, PEN, PWR, PADDR, PWDAT,
    output PRDY, PRDAT, PSLVERR, PROTERR
  );
endinterface

// File: rtl/apb_wait_slave.sv
// rtl/apb_wait_slave.sv - APB completer with register file, programmable wait states and error flags
module apb_wait_slave #(
  parameter int              ADDR_W       = 8,
  parameter int              DATA_W       = 8,
  parameter int              DEPTH        = 16,
  parameter int              WAIT_DEFAULT = 2,
  parameter logic [ADDR_W-1:0] CFG_ADDR   = {ADDR_W{1'b1}}
) (
  input  logic            PCLK,
  input  logic            PRST,
  apb_wait_slave_if.slave bus
);
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] cnt;
  logic [DATA_W-1:0] wait_reg;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdat_q;
  logic              wr_q;
  logic              err_q;
  logic [DATA_W-1:0] rdat_q;
  logic              proterr_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              latch;
  logic              ena_err;
  logic              abort;
  logic              addr_bad;
  logic              commit;
  logic [DATA_W-1:0] rd_val;

  // Only the latched address decides the response; live PADDR is ignored once in ACCESS.
  assign addr_bad    = (addr_q >= DEPTH_A) && (addr_q != CFG_ADDR);
  assign bus.PRDY    = (state == ACCESS) && bus.PSEL && bus.PEN && (cnt == '0);
  assign bus.PSLVERR = bus.PRDY && (addr_bad || err_q);
  assign bus.PRDAT   = rdat_q;
  assign bus.PROTERR = proterr_q;
  assign commit      = bus.PRDY && wr_q && !err_q && !addr_bad;

  // Read value captured at SETUP: storage, the wait register, or zero for unmapped addresses.
  always_comb begin
    rd_val = '0;
    if (bus.PADDR == CFG_ADDR) begin
      rd_val = wait_reg;
    end else if (bus.PADDR < DEPTH_A) begin
      rd_val = mem[bus.PADDR[IDX_W-1:0]];
    end
  end

  // Next-state decode plus the one-cycle strobes that steer the datapath.
  always_comb begin
    state_n = state;
    latch   = 1'b0;
    ena_err = 1'b0;
    abort   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.PSEL && !bus.PEN) begin
          latch   = 1'b1;
          state_n = SETUP;
        end else if (bus.PSEL && bus.PEN) begin
          ena_err = 1'b1;
          state_n = ACCESS;
        end
      end
      SETUP: begin
        if (!bus.PSEL) begin
          state_n = IDLE;
        end else if (bus.PEN) begin
          state_n = ACCESS;
        end else begin
          latch = 1'b1;
        end
      end
      ACCESS: begin
        if (!(bus.PSEL && bus.PEN)) begin
          abort   = 1'b1;
          state_n = IDLE;
        end else if (cnt == '0) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge PCLK) begin
    if (!PRST) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Transfer latches, wait counter, config register, read data and sticky protocol flag.
  always_ff @(posedge PCLK) begin
    if (!PRST) begin
      cnt       <= '0;
      wait_reg  <= DATA_W'(WAIT_DEFAULT);
      addr_q    <= '0;
      wdat_q    <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      rdat_q    <= '0;
      proterr_q <= 1'b0;
    end else begin
      if (latch) begin
        addr_q <= bus.PADDR;
        wdat_q <= bus.PWDAT;
        wr_q   <= bus.PWR;
        err_q  <= 1'b0;
        cnt    <= wait_reg;
        if (!bus.PWR) begin
          rdat_q <= rd_val;
        end
      end else if (ena_err) begin
        err_q     <= 1'b1;
        wr_q      <= bus.PWR;
        cnt       <= '0;
        proterr_q <= 1'b1;
        if (!bus.PWR) begin
          rdat_q <= '0;
        end
      end else if (abort) begin
        cnt       <= '0;
        proterr_q <= 1'b1;
      end else if ((state == ACCESS) && (cnt != '0)) begin
        cnt <= cnt - DATA_W'(1);
      end
      if (commit && (addr_q == CFG_ADDR)) begin
        wait_reg <= wdat_q;
      end
    end
  end

  // Storage writes; contents deliberately survive reset.
  always_ff @(posedge PCLK) begin
    if (PRST && commit && (addr_q < DEPTH_A)) begin
      mem[addr_q[IDX_W-1:0]] <= wdat_q;
    end
  end
endmodule

// File: tb/tb_apb_wait_slave.sv
// tb/tb_apb_wait_slave.sv - self-checking bench for apb_wait_slave
module tb_apb_wait_slave;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         exp_wait;
    logic [7:0] exp_rdat;
    bit         exp_err;
    bit         glitch;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  apb_wait_slave_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  apb_wait_slave #(
    .ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_DEFAULT(2), .CFG_ADDR(8'hFF)
  ) dut (
    .PCLK(clk),
    .PRST(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                              input int exp_wait, input logic [7:0] exp_rdat,
                              input bit exp_err, input bit glitch);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.exp_wait = exp_wait;
    v.exp_rdat = exp_rdat; v.exp_err = exp_err; v.glitch = glitch;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    vec_t e;
    int   waits;
    bit   got;
    sb.push_back(v);
    @(posedge clk); #1;
    bus.PSEL = 1'b1; bus.PEN = 1'b0; bus.PWR = v.wr; bus.PADDR = v.addr; bus.PWDAT = v.wdata;
    @(posedge clk); #1;
    bus.PEN = 1'b1;
    @(posedge clk); #1;
    if (v.glitch) begin
      bus.PADDR = 8'h05;
      bus.PWDAT = 8'hFF;
    end
    waits = 0;
    got   = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (bus.PRDY) begin
        got = 1'b1;
      end else begin
        waits++;
        @(posedge clk); #1;
      end
    end
    e = sb.pop_front();
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s timeout: PRDY never rose, expected after %0d waits", tag, e.exp_wait);
    end else begin
      chk({tag, " waits"}, waits, e.exp_wait);
      chk({tag, " pslverr"}, 32'(bus.PSLVERR), 32'(e.exp_err));
      if (!e.wr) chk({tag, " prdat"}, 32'(bus.PRDAT), 32'(e.exp_rdat));
    end
    @(posedge clk); #1;
    bus.PSEL = 1'b0;
    bus.PEN  = 1'b0;
  endtask

  initial begin
    bus.PSEL = 1'b0; bus.PEN = 1'b0; bus.PWR = 1'b0; bus.PADDR = '0; bus.PWDAT = '0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset prdy", 32'(bus.PRDY), 0);
    chk("reset pslverr", 32'(bus.PSLVERR), 0);
    chk("reset prdat", 32'(bus.PRDAT), 0);
    chk("reset proterr", 32'(bus.PROTERR), 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    tbl.push_back(mk(1, 8'h03, 8'hA5, 2, 8'h00, 0, 0));
    tbl.push_back(mk(0, 8'h03, 8'h00, 2, 8'hA5, 0, 0));
    tbl.push_back(mk(1, 8'h00, 8'h77, 2, 8'h00, 0, 0));
    tbl.push_back(mk(1, 8'h05, 8'h66, 2, 8'h00, 0, 0));
    tbl.push_back(mk(1, 8'h06, 8'h12, 2, 8'h00, 0, 0));
    tbl.push_back(mk(1, 8'h01, 8'h21, 2, 8'h00, 0, 0));
    tbl.push_back(mk(1, 8'hFF, 8'h00, 2, 8'h00, 0, 0));
    tbl.push_back(mk(1, 8'h07, 8'h3C, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 8'h07, 8'h00, 0, 8'h3C, 0, 0));
    tbl.push_back(mk(0, 8'hFF, 8'h00, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 8'hFF, 8'h02, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 8'h20, 8'h55, 2, 8'h00, 1, 0));
    tbl.push_back(mk(0, 8'h20, 8'h00, 2, 8'h00, 1, 0));
    tbl.push_back(mk(0, 8'h00, 8'h00, 2, 8'h77, 0, 0));
    tbl.push_back(mk(1, 8'h04, 8'h11, 2, 8'h00, 0, 1));
    tbl.push_back(mk(0, 8'h04, 8'h00, 2, 8'h11, 0, 0));
    tbl.push_back(mk(0, 8'h05, 8'h00, 2, 8'h66, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // PSEL dropped after one wait cycle: no write, sticky PROTERR.
    @(posedge clk); #1;
    bus.PSEL = 1'b1; bus.PEN = 1'b0; bus.PWR = 1'b1; bus.PADDR = 8'h06; bus.PWDAT = 8'h99;
    @(posedge clk); #1;
    bus.PEN = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("drop first wait prdy", 32'(bus.PRDY), 0);
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PEN = 1'b0;
    @(negedge clk);
    chk("drop gated prdy", 32'(bus.PRDY), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drop proterr", 32'(bus.PROTERR), 1);
    run_vec(mk(0, 8'h06, 8'h00, 2, 8'h12, 0, 0), "after_drop");

    // Enable without setup: one-cycle PRDY with PSLVERR, no write.
    @(posedge clk); #1;
    bus.PSEL = 1'b1; bus.PEN = 1'b1; bus.PWR = 1'b1; bus.PADDR = 8'h01; bus.PWDAT = 8'hEE;
    @(posedge clk); #1;
    @(negedge clk);
    chk("noset prdy", 32'(bus.PRDY), 1);
    chk("noset pslverr", 32'(bus.PSLVERR), 1);
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PEN = 1'b0;
    @(negedge clk);
    chk("noset prdy low", 32'(bus.PRDY), 0);
    chk("noset proterr", 32'(bus.PROTERR), 1);
    run_vec(mk(0, 8'h01, 8'h00, 2, 8'h21, 0, 0), "after_noset");

    // Non-default wait, then reset during a write's wait cycle.
    run_vec(mk(1, 8'hFF, 8'h05, 2, 8'h00, 0, 0), "cfg5");
    run_vec(mk(0, 8'h03, 8'h00, 5, 8'hA5, 0, 0), "wait5");
    @(posedge clk); #1;
    bus.PSEL = 1'b1; bus.PEN = 1'b0; bus.PWR = 1'b1; bus.PADDR = 8'h03; bus.PWDAT = 8'hC3;
    @(posedge clk); #1;
    bus.PEN = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    bus.PSEL = 1'b0; bus.PEN = 1'b0;
    @(negedge clk);
    chk("rst prdy", 32'(bus.PRDY), 0);
    chk("rst prdat", 32'(bus.PRDAT), 0);
    chk("rst proterr", 32'(bus.PROTERR), 0);
    run_vec(mk(0, 8'h03, 8'h00, 2, 8'hA5, 0, 0), "after_rst");
    run_vec(mk(0, 8'hFF, 8'h00, 2, 8'h02, 0, 0), "cfg_default");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apb_wait_slave.md
Name: apb_wait_slave

Overview:
- APB completer that sits directly downstream of the team's APB master FSM and consumes its PSEL/PEN/PWR/PADDR/PWDAT stream.
- Holds a DEPTH-entry register file plus one runtime wait-state config register.
- Stretches the ACCESS phase by a programmable number of wait cycles via PRDY and flags bad addresses via PSLVERR.
- Intended as the realistic-slave replacement for the zero-wait completer in the APB bench.

Parameters:
ADDR_W, 8, width of PADDR
DATA_W, 8, width of PWDAT/PRDAT
DEPTH, 16, number of storage registers, mapped at addresses 0..DEPTH-1 (DEPTH <= 2^ADDR_W - 1)
WAIT_DEFAULT, 2, reset value of the wait-state register, range 0..255
CFG_ADDR, 8'hFF, address of the wait-state register (outside 0..DEPTH-1)

Ports:
PCLK  in  1  clock, all logic on rising edge
PRST  in  1  reset, synchronous, active-low; state is cleared on a PCLK edge with PRST==0
PSEL  in  1  APB select
PEN  in  1  APB enable
PWR  in  1  1 = write, 0 = read
PADDR  in  ADDR_W  address
PWDAT  in  DATA_W  write data
PRDY  out  1  transfer complete
PRDAT  out  DATA_W  read data, registered
PSLVERR  out  1  error response, valid only while PRDY==1
PROTERR  out  1  sticky protocol-violation flag

Behaviour:
- Reset, on an edge with PRST==0:
  - FSM goes to IDLE; wait counter = 0; wait register = WAIT_DEFAULT.
  - PRDAT = 0, PROTERR = 0, latched address/data/dir = 0.
  - Storage contents are not reset; bench must write before reading.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - PSEL=1, PEN=0 at an edge -> SETUP. At that edge:
    - latch PADDR, PWDAT, PWR;
    - load counter = wait register;
    - if read, load PRDAT = mem[PADDR] (or the wait register if PADDR==CFG_ADDR; 0 if out of range).
  - PSEL=1, PEN=1 (enable without setup) -> set PROTERR (sticky until reset) and move to ACCESS with counter = 0 and an error flag. Gives a one-cycle PRDY=1 with PSLVERR=1; no write.
- SETUP:
  - PSEL=1, PEN=1 -> ACCESS.
  - PSEL=0 -> IDLE (abort, nothing committed).
  - PSEL=1, PEN=0 -> stay in SETUP and re-latch address/data/dir/PRDAT.
- ACCESS:
  - PRDY = (state==ACCESS) && PSEL && PEN && (counter==0). Combinational from registered state, so there is no input-to-output path other than the PSEL/PEN gating.
  - While counter != 0, each edge decrements it; PRDY stays 0.
  - Wait cycles per transfer are exactly the value of the wait register at setup. A value of 0 gives PRDY=1 in the first ACCESS cycle.
  - On the edge where PRDY==1:
    - a write commits the latched data to mem[latched addr], or to the wait register if addr==CFG_ADDR;
    - FSM goes to IDLE.
  - Back-to-back transfers: the master returns via its IDLE, so there is no direct ACCESS->SETUP arc.
  - PSEL or PEN drops before PRDY -> IDLE, counter cleared, no write, PROTERR set.
- Addresses are the latched copy. PADDR/PWDAT changes during ACCESS are ignored.
- PSLVERR = PRDY && (latched addr >= DEPTH and != CFG_ADDR, or enable-without-setup error). An erroring write does not modify storage; an erroring read returns PRDAT=0.
- A write to CFG_ADDR takes effect from the next SETUP. The current transfer keeps its already-loaded count.
- PRDAT holds its value after a read completes until the next read SETUP; writes do not change PRDAT.
- Reset asserted mid-transfer: the edge overrides everything. No write commits on that edge, even if PRDY was 1.

Test Plan:
- Write 8'hA5 to addr 3, default wait 2 -> PRDY low for 2 ACCESS cycles, high on the 3rd; read addr 3 -> PRDAT=8'hA5, PSLVERR=0, same 3-cycle ACCESS.
- Write 8'h00 to CFG_ADDR, then write/read addr 7 with 8'h3C -> PRDY=1 in the first ACCESS cycle; read of CFG_ADDR returns 8'h00.
- Write 8'h55 to addr 8'h20 (>= DEPTH) -> PRDY after the wait, PSLVERR=1, storage unchanged; read 8'h20 -> PRDAT=0, PSLVERR=1.
- Change PADDR/PWDAT to 5/8'hFF during ACCESS of a write to addr 4/8'h11 -> mem[4]=8'h11, mem[5] unchanged.
- PSEL dropped after 1 wait cycle -> no write, FSM back to IDLE, PROTERR=1; PSEL+PEN together from IDLE -> 1-cycle PRDY with PSLVERR=1.
- PRST=0 during a wait cycle of a write -> PRDY=0, PRDAT=0, wait register = WAIT_DEFAULT, target register unchanged.
